fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, PC and instruction-memory address width.
REQ-002 Parameter DATA_WIDTH, default 16, instruction width.
REQ-003 Parameter RESET_PC, default 16'h0000, first fetch address after start.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins fetching from RESET_PC.
REQ-007 pc  output  ADDR_WIDTH  address driven to instruction memory; combinational read returns instruction the same cycle.
REQ-008 instruction  input  DATA_WIDTH  instruction-memory read data for pc.
REQ-009 stall  input  1  decode not ready; hold PC and IF/ID contents.
REQ-010 redirect  input  1  taken branch or jump from execute.
REQ-011 redirect_pc  input  ADDR_WIDTH  target address, valid with redirect.
REQ-012 if_id_instr  output  DATA_WIDTH  registered instruction to decode.
REQ-013 if_id_pc  output  ADDR_WIDTH  registered address of if_id_instr.
REQ-014 if_id_valid  output  1  if_id_instr is a real instruction, not a bubble.
REQ-015 halted  output  1  high while FSM is in HALTED.

Function
REQ-016 FSM states: IDLE, FETCH, HALTED; pc increments only in FETCH.
REQ-017 IDLE: pc holds RESET_PC, if_id_valid=0; start moves to FETCH next cycle with pc=RESET_PC.
REQ-018 FETCH, no stall, no redirect: if_id_instr<=instruction, if_id_pc<=pc, if_id_valid<=1, pc<=pc+1 (word addressed), one-cycle fetch latency.
REQ-019 pc increment wraps modulo 2^ADDR_WIDTH (16'hFFFF -> 16'h0000), with no flag.
REQ-020 Priority each cycle: redirect > stall > normal advance.
REQ-021 redirect, in any state other than IDLE: pc<=redirect_pc, if_id_valid<=0 (flush), state<=FETCH; this holds even when stall is high.
REQ-022 stall without redirect: pc, if_id_instr, if_id_pc, if_id_valid and state all hold.
REQ-023 FETCH with instruction[15:12]==OPC_HALT, no stall, no redirect: the instruction is latched with if_id_valid=1, pc holds, state<=HALTED.
REQ-024 HALTED: pc holds; if_id_valid<=0 on the first non-stalled cycle; halted=1; exits only by redirect or reset.
REQ-025 start is ignored outside IDLE.
REQ-026 Outputs change only on clk rising edge or rst_n assertion; there is no combinational path from instruction to any output.

Reset
REQ-027 rst_n low, asynchronously: state=IDLE, pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0.
REQ-028 Reset asserted mid-fetch or mid-stall discards all state; after release the block waits for start.
REQ-029 Reset deassertion takes effect at the first clk edge after rst_n goes high.

Structure
REQ-030 Shared package cpu_pkg holds ADDR_WIDTH/DATA_WIDTH defaults, OPC_HALT=4'hF, and the fetch state enum.
REQ-031 One sub-module if_id_reg (data/pc/valid register with hold and flush controls); fetch_stage holds the FSM and PC logic.
REQ-032 Block connects to the existing dual-port instruction memory read port: pc -> address, data -> instruction.

Verification
REQ-033 Reset, start, memory 0..3 = non-halt words, no stall: pc 0,1,2,3; if_id_pc 0,1,2 one cycle later; if_id_valid=1 from second FETCH cycle.
REQ-034 stall high 3 cycles at pc=5: pc=5 and if_id unchanged for 3 cycles; pc=6 on the first cycle after stall drops.
REQ-035 redirect with redirect_pc=16'h0040 and stall=1 at pc=7: next cycle pc=16'h0040, if_id_valid=0; the following cycle if_id_pc=16'h0040, valid=1.
REQ-036 Word 16'hF000 at address 3: if_id_instr=16'hF000 valid, halted=1, pc stays 3, if_id_valid=0 next cycle; redirect to 0 resumes FETCH.
REQ-037 redirect_pc=16'hFFFF: pc goes FFFF -> 0000 -> 0001 with valid instructions throughout.
REQ-038 rst_n pulsed low mid-stream, asynchronous to clk: outputs reach reset values immediately; pc holds RESET_PC until start.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, opcode constants and fetch FSM encoding.
package cpu_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 16;
   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam logic [3:0]  OPC_HALT       = 4'hF;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StFetch  = 2'd1,
      StHalted = 2'd2
   } fetch_state_e;

   function automatic logic is_halt(input logic [3:0] opcode);
      return opcode == OPC_HALT;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures instruction and address, with hold and flush controls.
module if_id_reg #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] next_instr,
   input  logic [ADDR_WIDTH-1:0] next_pc,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  valid
);

   logic [DATA_WIDTH-1:0] instr_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic                  valid_q;

   // Flush only kills the valid bit; stale data is harmless once marked a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (!hold) begin
         instr_q <= next_instr;
         pc_q    <= next_pc;
         valid_q <= 1'b1;
      end
   end

   assign instr = instr_q;
   assign pc    = pc_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, halt detection and redirect handling feeding IF/ID.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] instruction,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] if_id_instr,
   output logic [ADDR_WIDTH-1:0] if_id_pc,
   output logic                  if_id_valid,
   output logic                  halted
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  reg_hold;
   logic                  reg_flush;
   logic                  halt_opc;

   assign halt_opc = is_halt(instruction[DATA_WIDTH-1 -: 4]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Redirect outranks stall; both outrank normal advance.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      reg_hold  = 1'b1;
      reg_flush = 1'b0;
      if (redirect && (state_q != StIdle)) begin
         pc_d      = redirect_pc;
         reg_flush = 1'b1;
         state_d   = StFetch;
      end else begin
         unique case (state_q)
            StIdle: begin
               pc_d = RESET_PC;
               if (start) begin
                  state_d = StFetch;
               end
            end
            StFetch: begin
               if (!stall) begin
                  reg_hold = 1'b0;
                  if (halt_opc) begin
                     state_d = StHalted;
                  end else begin
                     pc_d = pc_q + ADDR_WIDTH'(1);
                  end
               end
            end
            StHalted: begin
               if (!stall) begin
                  reg_flush = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               pc_d    = RESET_PC;
            end
         endcase
      end
   end

   if_id_reg #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_if_id_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (reg_hold),
      .flush     (reg_flush),
      .next_instr(instruction),
      .next_pc   (pc_q),
      .instr     (if_id_instr),
      .pc        (if_id_pc),
      .valid     (if_id_valid)
   );

   assign pc     = pc_q;
   assign halted = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed sequences push expected IF/ID captures, a monitor checks them.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] pc;
   logic [15:0] instruction;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc;
   logic        if_id_valid;
   logic        halted;

   logic        halt_en;
   logic [15:0] halt_addr;
   logic        stall_edge;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pc         (pc),
      .instruction(instruction),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .if_id_instr(if_id_instr),
      .if_id_pc   (if_id_pc),
      .if_id_valid(if_id_valid),
      .halted     (halted)
   );

   function automatic logic [15:0] word_at(input logic [15:0] a);
      if (halt_en && a == halt_addr) return 16'hF000;
      return {4'h1, a[11:0]};
   endfunction

   // Combinational instruction memory
   assign instruction = word_at(pc);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] a);
      exp_t e;
      e.instr = i;
      e.pc    = a;
      exp_q.push_back(e);
   endtask

   // Normal advance from pc a for n cycles; expects capture of each word and pc increment.
   task automatic adv(input logic [15:0] a, input int n);
      logic [15:0] p;
      p = a;
      for (int k = 0; k < n; k++) begin
         push(word_at(p), p);
         tick();
         p = p + 16'd1;
         chk("adv_pc", 32'(pc), 32'(p));
      end
   endtask

   initial begin
      stall_edge = 1'b0;
      forever begin
         @(posedge clk);
         stall_edge = stall;
      end
   end

   // Monitor: a valid output after a non-stalled edge is a fresh capture.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && !stall_edge && if_id_valid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got pc %h instr %h expected none", if_id_pc, if_id_instr);
            end else begin
               e = exp_q.pop_front();
               if (if_id_instr !== e.instr || if_id_pc !== e.pc) begin
                  bad++;
                  $display("FAIL sb_capture: got pc %h instr %h expected pc %h instr %h",
                           if_id_pc, if_id_instr, e.pc, e.instr);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      halt_en     = 1'b0;
      halt_addr   = 16'h0003;
      #12;
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'h0);
      chk("rst_instr", 32'(if_id_instr), 32'h0);
      chk("rst_ifpc", 32'(if_id_pc), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_pc", 32'(pc), 32'h0);
      chk("idle_valid", 32'(if_id_valid), 32'h0);

      // Start and sequential fetch
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_pc", 32'(pc), 32'h0);
      chk("start_valid", 32'(if_id_valid), 32'h0);
      adv(16'h0000, 1);
      chk("first_valid", 32'(if_id_valid), 32'h1);
      chk("first_ifpc", 32'(if_id_pc), 32'h0);
      adv(16'h0001, 4);

      // Stall at pc=5
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_pc", 32'(pc), 32'h5);
         chk("stall_ifpc", 32'(if_id_pc), 32'h4);
         chk("stall_valid", 32'(if_id_valid), 32'h1);
      end
      stall = 1'b0;
      adv(16'h0005, 2);

      // Redirect with stall at pc=7
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      stall       = 1'b1;
      tick();
      redirect = 1'b0;
      stall    = 1'b0;
      chk("redir_pc", 32'(pc), 32'h40);
      chk("redir_valid", 32'(if_id_valid), 32'h0);
      adv(16'h0040, 1);
      chk("redir_ifpc", 32'(if_id_pc), 32'h40);
      chk("redir_valid2", 32'(if_id_valid), 32'h1);

      // Halt at address 3
      redirect    = 1'b1;
      redirect_pc = 16'h0000;
      tick();
      redirect = 1'b0;
      chk("to0_pc", 32'(pc), 32'h0);
      halt_en = 1'b1;
      adv(16'h0000, 3);
      push(16'hF000, 16'h0003);
      tick();
      chk("halt_pc", 32'(pc), 32'h3);
      chk("halt_flag", 32'(halted), 32'h1);
      chk("halt_valid", 32'(if_id_valid), 32'h1);
      chk("halt_instr", 32'(if_id_instr), 32'hF000);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("halt_bubble", 32'(if_id_valid), 32'h0);
      chk("halt_pc2", 32'(pc), 32'h3);
      chk("halt_flag2", 32'(halted), 32'h1);
      tick();
      chk("halt_hold", 32'(halted), 32'h1);
      halt_en     = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 16'h0000;
      tick();
      redirect = 1'b0;
      chk("resume_halted", 32'(halted), 32'h0);
      chk("resume_pc", 32'(pc), 32'h0);
      adv(16'h0000, 1);

      // Wrap at top of address space
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      tick();
      redirect = 1'b0;
      chk("wrap_start", 32'(pc), 32'hFFFF);
      adv(16'hFFFF, 3);

      // Asynchronous reset mid-stall
      stall = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", 32'(pc), 32'h0);
      chk("arst_valid", 32'(if_id_valid), 32'h0);
      chk("arst_ifpc", 32'(if_id_pc), 32'h0);
      chk("arst_instr", 32'(if_id_instr), 32'h0);
      #1;
      rst_n = 1'b1;
      stall = 1'b0;
      @(negedge clk);
      tick();
      tick();
      chk("post_rst_pc", 32'(pc), 32'h0);
      chk("post_rst_valid", 32'(if_id_valid), 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      adv(16'h0000, 2);

      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
